// File: rtl/smu_rv32i_pkg.sv
// Shared types and defaults for the smu_rv32i data-memory subsystem.
package smu_rv32i_pkg;

    localparam int unsigned SMU_MAX_BURST = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Advance a burst count by one access, holding at the 4-bit ceiling.
    function automatic logic [3:0] burst_step(input logic [3:0] cnt, input logic hit);
        logic [3:0] nxt;
        if (!hit) begin
            nxt = cnt;
        end else if (cnt == 4'hF) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for one single-ported data memory (CPU data port vs loader/debug).
// Optional round-robin tie-break and burst-cap handoff: define DMEM_ARB_RR_EN.
module dmem_port_arbiter
    import smu_rv32i_pkg::*;
#(
    parameter int unsigned AWIDTH    = 12,
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned MAX_BURST = SMU_MAX_BURST
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_gnt,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    input  logic [3:0]        m1_be,
    output logic              m1_gnt,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    output logic              mem_wen,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

    arb_state_e        state_q, state_d;
    arb_state_e        tie_win_s;
    logic [3:0]        burst_q, burst_d;
    logic [3:0]        burst_inc_s;
    logic              cap_hit_s;
    logic              own0_s, own1_s;
    logic              acc0_s, acc1_s, acc_s;
    logic              rd0_s, rd1_s;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [DWIDTH-1:0] rdata0_q, rdata0_d;
    logic [DWIDTH-1:0] rdata1_q, rdata1_d;
    logic              unused_addr_s;

    // Only word-address bits reach the memory; the rest are intentionally dropped.
    assign unused_addr_s = ^{m0_addr, m1_addr};

    // Ownership decode and per-cycle access qualification; n_rst kills an access at once.
    always_comb begin
        own0_s = (state_q == ST_OWN0);
        own1_s = (state_q == ST_OWN1);
        acc0_s = own0_s & m0_req & n_rst;
        acc1_s = own1_s & m1_req & n_rst;
        acc_s  = acc0_s | acc1_s;
        rd0_s  = acc0_s & ~m0_we;
        rd1_s  = acc1_s & ~m1_we;
    end

    assign m0_gnt    = own0_s;
    assign m1_gnt    = own1_s;
    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

    // Memory port mux: owner's payload during an access, all-zero otherwise.
    always_comb begin
        mem_addr  = {AWIDTH{1'b0}};
        mem_wdata = {DWIDTH{1'b0}};
        mem_be    = 4'b0000;
        mem_wen   = 1'b0;
        if (acc0_s) begin
            mem_addr  = m0_addr[AWIDTH+1:2];
            mem_wdata = m0_wdata;
            mem_be    = m0_be;
            mem_wen   = m0_we;
        end else if (acc1_s) begin
            mem_addr  = m1_addr[AWIDTH+1:2];
            mem_wdata = m1_wdata;
            mem_be    = m1_be;
            mem_wen   = m1_we;
        end else begin
            mem_addr  = {AWIDTH{1'b0}};
            mem_wdata = {DWIDTH{1'b0}};
            mem_be    = 4'b0000;
            mem_wen   = 1'b0;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Last-owner flag: 1 means master 0 owned last, so the next tie favours master 1.
    logic last_m0_q, last_m0_d;

    assign tie_win_s = last_m0_q ? ST_OWN1 : ST_OWN0;

    // Record whichever master is about to take the port.
    always_comb begin
        if (state_d == ST_OWN0) begin
            last_m0_d = 1'b1;
        end else if (state_d == ST_OWN1) begin
            last_m0_d = 1'b0;
        end else begin
            last_m0_d = last_m0_q;
        end
    end

    // Last-owner register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_m0_q <= 1'b1;
        end else begin
            last_m0_q <= last_m0_d;
        end
    end
`else
    assign tie_win_s = ST_OWN0;
`endif

    // Arbitration next-state and burst counter.
    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        burst_inc_s = burst_step(burst_q, acc_s);
        cap_hit_s   = (burst_inc_s >= BURST_CAP);
        case (state_q)
            ST_IDLE: begin
                burst_d = 4'd0;
                if (m0_req && m1_req) begin
                    state_d = tie_win_s;
                end else if (m0_req) begin
                    state_d = ST_OWN0;
                end else if (m1_req) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!m0_req) begin
                    burst_d = 4'd0;
                    state_d = m1_req ? ST_OWN1 : ST_IDLE;
                end else if (cap_hit_s && m1_req) begin
                    burst_d = 4'd0;
                    state_d = ST_OWN1;
                end else begin
                    burst_d = burst_inc_s;
                    state_d = ST_OWN0;
                end
            end
            ST_OWN1: begin
                if (!m1_req) begin
                    burst_d = 4'd0;
                    state_d = m0_req ? ST_OWN0 : ST_IDLE;
                end else if (cap_hit_s && m0_req) begin
                    burst_d = 4'd0;
                    state_d = ST_OWN0;
                end else begin
                    burst_d = burst_inc_s;
                    state_d = ST_OWN1;
                end
            end
            default: begin
                burst_d = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read return: capture memory data on a read access, hold it until that master reads again.
    always_comb begin
        rvalid0_d = rd0_s;
        rvalid1_d = rd1_s;
        if (rd0_s) begin
            rdata0_d = mem_rdata;
        end else begin
            rdata0_d = rdata0_q;
        end
        if (rd1_s) begin
            rdata1_d = mem_rdata;
        end else begin
            rdata1_d = rdata1_q;
        end
    end

    // State, burst and read-return registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            burst_q   <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= {DWIDTH{1'b0}};
            rdata1_q  <= {DWIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

endmodule

// File: doc/dmem_port_arbiter.md
DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 12, word-address width of the shared memory port.
REQ-002 SHALL have parameter DWIDTH, default 32, data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, the most consecutive accesses one master may make while the other master waits; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-005 SHALL have port n_rst, input, 1 bit; reset, asynchronous, active-low.
REQ-006 SHALL have, for each master x in {0,1}, the following ports: mx_req in 1; mx_we in 1; mx_addr in 32 (byte address); mx_wdata in DWIDTH; mx_be in 4; mx_gnt out 1; mx_rdata out DWIDTH; mx_rvalid out 1. Master 0 is the CPU data port; master 1 is the loader/debug master.
REQ-007 SHALL have the following memory-side ports: mem_addr out AWIDTH; mem_wdata out DWIDTH; mem_be out 4; mem_wen out 1; mem_rdata in DWIDTH (asynchronous-read data).

Function
REQ-008 SHALL implement an FSM with states IDLE, OWN0 and OWN1; mx_gnt SHALL be 1 only in state OWNx.
REQ-009 SHALL leave IDLE when any mx_req=1, entering OWN0 or OWN1 per REQ-016 on the next edge, so latency from req to gnt is 1 cycle.
REQ-010 SHALL perform exactly one memory access in each cycle where mx_gnt=1 and mx_req=1.
REQ-011 SHALL drive the memory port with mem_addr=mx_addr[AWIDTH+1:2], mem_wdata=mx_wdata, mem_be=mx_be and mem_wen=mx_we during each access (combinational path from the owner's inputs).
REQ-012 SHALL drive mem_wen=0, mem_be=0, mem_addr=0 and mem_wdata=0 in every cycle with no access.
REQ-013 SHALL, for a read access (mx_we=0), register mem_rdata into mx_rdata and pulse mx_rvalid=1 for one cycle on the following edge; mx_rdata SHALL hold its value until the next read by that master. Writes SHALL produce no rvalid.
REQ-014 SHALL count accesses of the current owner in a 4-bit burst counter, cleared on every ownership change and on return to IDLE.
REQ-015 SHALL handle ownership transitions on each edge in OWNx as follows:
- mx_req=0 and the other master's req=1: move to the other OWN state.
- mx_req=0 and the other master's req=0: move to IDLE.
- burst count reaches MAX_BURST and the other master's req=1: move to the other OWN state.
- otherwise: stay in OWNx.
REQ-016 SHALL resolve simultaneous requests in IDLE so that master 0 wins (fixed priority), except as modified by REQ-021.
REQ-017 SHALL ignore the requester's req, we, addr, wdata and be in any cycle without gnt; a master SHALL hold req and its payload stable until it sees gnt.
REQ-018 SHALL never assert m0_gnt and m1_gnt in the same cycle.

Reset
REQ-019 SHALL, while n_rst=0, force the state to IDLE, the burst counter to 0, m0_gnt, m1_gnt, m0_rvalid and m1_rvalid to 0, and m0_rdata and m1_rdata to 0; memory outputs then follow REQ-012.
REQ-020 SHALL, on reset asserted mid-access, suppress mem_wen in that same cycle (asynchronously), drop any pending rvalid, and restart arbitration from IDLE after deassertion.

Configuration
REQ-021 SHALL, with macro DMEM_ARB_RR_EN defined, keep a last-owner register (reset value 1) and resolve IDLE ties and burst-cap handoffs round-robin in favour of the master that was not the last owner; without the macro, IDLE ties SHALL use fixed priority (master 0) and the last-owner register SHALL not exist.

Structure
REQ-022 SHALL take the state enum (IDLE/OWN0/OWN1) and the MAX_BURST default from the shared package smu_rv32i_pkg.
REQ-023 SHALL be a single module with no sub-modules; per-master request muxing SHALL be inline.

Verification
REQ-024 SHALL verify single read: m0 reads 0x0000_0010 from preloaded word 4 = 0xDEADBEEF -> m0_gnt 1 cycle after req, mem_addr=4, m0_rvalid next cycle with m0_rdata=0xDEADBEEF.
REQ-025 SHALL verify single write: m1 writes 0x1234_5678, be=4'b0011, to 0x0000_0020 -> exactly one cycle with mem_wen=1, mem_addr=8, mem_be=4'b0011; no rvalid.
REQ-026 SHALL verify collision: both masters request in the same IDLE cycle -> m0 granted first without the macro, m1 granted first with DMEM_ARB_RR_EN after reset; never both gnt.
REQ-027 SHALL verify burst cap: m0 holds req for 10 accesses while m1 requests, MAX_BURST=4 -> m0 gets 4 accesses, then m1 is granted on the next edge.
REQ-028 SHALL verify reset mid-write: n_rst=0 during m0 write cycle -> mem_wen=0 immediately, all gnt/rvalid 0, FSM in IDLE, first gnt 1 cycle after a post-reset req.
